// File: rtl/tft_timing_gen_pkg.sv
// rtl/tft_timing_gen_pkg.sv - 640x480 raster timing defaults and derived window edges.
package tft_timing_gen_pkg;
    localparam int CNT_W = 10;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_TOTAL_DEF  = H_SYNC_DEF + H_BP_DEF + H_ACTIVE_DEF + H_FP_DEF;

    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_TOTAL_DEF  = V_SYNC_DEF + V_BP_DEF + V_ACTIVE_DEF + V_FP_DEF;

    localparam int HA0_DEF = H_SYNC_DEF + H_BP_DEF;
    localparam int HA1_DEF = HA0_DEF + H_ACTIVE_DEF - 1;
    localparam int VA0_DEF = V_SYNC_DEF + V_BP_DEF;
    localparam int VA1_DEF = VA0_DEF + V_ACTIVE_DEF - 1;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t to_cnt(input int v);
        return cnt_t'(v);
    endfunction
endpackage

// File: rtl/tft_timing_gen_axis_cnt.sv
// rtl/tft_timing_gen_axis_cnt.sv - one raster axis: wrapping counter with sync/active flags.
// Flags decode the next-state count so the parent can register them alongside the count.
module tft_axis_cnt
    import tft_timing_gen_pkg::*;
#(
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int TOTAL  = 800
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output cnt_t cnt,
    output cnt_t cnt_next,
    output logic wrap,
    output logic sync_nx,
    output logic active_nx
);
    localparam cnt_t LAST = to_cnt(TOTAL - 1);
    localparam cnt_t S_END = to_cnt(SYNC);
    localparam cnt_t A0 = to_cnt(SYNC + BP);
    localparam cnt_t A1 = to_cnt(SYNC + BP + ACTIVE - 1);

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        wrap  = en && !clr && (cnt_q == LAST);
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt       = cnt_q;
    assign cnt_next  = cnt_d;
    assign sync_nx   = cnt_d < S_END;
    assign active_nx = (cnt_d >= A0) && (cnt_d <= A1);
endmodule

// File: rtl/tft_timing_gen.sv
// rtl/tft_timing_gen.sv - TFT raster timing: syncs, DE, line-buffer read strobes, fetch pulses.
// Every output is registered from the next-state count so it lines up with h_cnt/v_cnt.
module tft_timing_gen
    import tft_timing_gen_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF
) (
    input  logic             tft_clk,
    input  logic             tft_rst,
    input  logic             tft_on_reg,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             DE,
    output logic             BRAM_TFT_rd,
    output logic             BRAM_TFT_oe,
    output logic             line_req,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt
);
    localparam int HA0 = H_SYNC + H_BP;
    localparam int HA1 = HA0 + H_ACTIVE - 1;
    localparam int VA0 = V_SYNC + V_BP;
    localparam int VA1 = VA0 + V_ACTIVE - 1;

    localparam cnt_t RD0  = to_cnt(HA0 - 2);
    localparam cnt_t RD1  = to_cnt(HA1 - 2);
    localparam cnt_t OE0  = to_cnt(HA0 - 1);
    localparam cnt_t OE1  = to_cnt(HA1 - 1);
    localparam cnt_t LR_H = to_cnt(HA1 + 1);
    localparam cnt_t LR_V0 = to_cnt(VA0 - 1);
    localparam cnt_t LR_V1 = to_cnt(VA1 - 1);

    cnt_t h_cur, h_nx, v_cur, v_nx;
    logic h_wrap, v_wrap, h_sync_nx, h_act_nx, v_sync_nx, v_act_nx;
    logic clr;

    logic run_q, run_d, on_q, on_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic rd_q, rd_d, oe_q, oe_d, line_req_q, line_req_d, frame_start_q, frame_start_d;
    logic vis;

    // run_q holds the counters at 0 for one cycle after reset so 0/0 is shown first.
    assign clr = !run_q;

    tft_axis_cnt #(.SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE),
                   .TOTAL(H_SYNC + H_BP + H_ACTIVE + H_FP)) u_h_cnt (
        .clk(tft_clk), .rst(tft_rst), .en(1'b1), .clr(clr),
        .cnt(h_cur), .cnt_next(h_nx), .wrap(h_wrap),
        .sync_nx(h_sync_nx), .active_nx(h_act_nx)
    );

    tft_axis_cnt #(.SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE),
                   .TOTAL(V_SYNC + V_BP + V_ACTIVE + V_FP)) u_v_cnt (
        .clk(tft_clk), .rst(tft_rst), .en(h_wrap), .clr(clr),
        .cnt(v_cur), .cnt_next(v_nx), .wrap(v_wrap),
        .sync_nx(v_sync_nx), .active_nx(v_act_nx)
    );

    always_comb begin
        run_d = 1'b1;
        on_d  = on_q;
        // The enable is only taken at the last pixel of the frame: no partial frames.
        if (v_wrap) begin
            on_d = tft_on_reg;
        end
        vis           = on_d && v_act_nx;
        hsync_d       = !h_sync_nx;
        vsync_d       = !v_sync_nx;
        de_d          = vis && h_act_nx;
        rd_d          = vis && (h_nx >= RD0) && (h_nx <= RD1);
        oe_d          = vis && (h_nx >= OE0) && (h_nx <= OE1);
        line_req_d    = on_d && (h_nx == LR_H) && (v_nx >= LR_V0) && (v_nx <= LR_V1);
        frame_start_d = (h_nx == '0) && (v_nx == '0);
    end

    always_ff @(posedge tft_clk) begin
        if (tft_rst) begin
            run_q         <= 1'b0;
            on_q          <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            rd_q          <= 1'b0;
            oe_q          <= 1'b0;
            line_req_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            run_q         <= run_d;
            on_q          <= on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            rd_q          <= rd_d;
            oe_q          <= oe_d;
            line_req_q    <= line_req_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HSYNC       = hsync_q;
    assign VSYNC       = vsync_q;
    assign DE          = de_q;
    assign BRAM_TFT_rd = rd_q;
    assign BRAM_TFT_oe = oe_q;
    assign line_req    = line_req_q;
    assign frame_start = frame_start_q;
    assign h_cnt       = h_cur;
    assign v_cnt       = v_cur;
endmodule
